ir_nec_emitter: RTL and testbench
=================================

IR_NEC_EMITTER -- requirements
Module: ir_nec_emitter

Interface
REQ-001 SHALL have parameter CARRIER_HALF, default 658, meaning clk cycles per carrier half-period (38 kHz at 50 MHz clk).
REQ-002 SHALL have parameter LEAD_MARK, default 450000, meaning leader mark length in clk cycles (9 ms).
REQ-003 SHALL have parameter LEAD_SPACE, default 225000, meaning leader space length in clk cycles (4.5 ms).
REQ-004 SHALL have parameter BIT_MARK, default 28125, meaning per-bit mark and stop mark length in clk cycles (562.5 us).
REQ-005 SHALL have parameter ZERO_SPACE, default 28125, meaning space after a 0 bit in clk cycles.
REQ-006 SHALL have parameter ONE_SPACE, default 84375, meaning space after a 1 bit in clk cycles.
REQ-007 SHALL have port clk  input  1  single system clock; all logic on posedge.
REQ-008 SHALL have port rst_n  input  1  synchronous, active-low reset.
REQ-009 SHALL have port start  input  1  request to send one frame, sampled each posedge.
REQ-010 SHALL have port data  input  8  command byte, captured when start is accepted.
REQ-011 SHALL have port ir_led  output  1  modulated IR LED drive.
REQ-012 SHALL have port busy  output  1  high while a frame is in progress.
REQ-013 SHALL have port done  output  1  one-cycle pulse at frame end.

Function
REQ-014 SHALL implement states IDLE, LEAD_M, LEAD_S, BIT_M, BIT_S, STOP_M.
REQ-015 SHALL accept start only in IDLE; accepting latches data and enters LEAD_M on the same edge; start while busy SHALL be ignored.
REQ-016 SHALL transmit a 16-bit payload: data[7:0] then ~data[7:0], LSB first, taken from the latched copy; changes to data during a frame SHALL have no effect.
REQ-017 SHALL stay in each state for exactly its parameter length: LEAD_M=LEAD_MARK, LEAD_S=LEAD_SPACE, BIT_M=BIT_MARK, BIT_S=ZERO_SPACE or ONE_SPACE per current payload bit, STOP_M=BIT_MARK.
REQ-018 SHALL sequence LEAD_M->LEAD_S->BIT_M->BIT_S, repeat BIT_M/BIT_S 16 times (4-bit index 0..15), then STOP_M->IDLE.
REQ-019 SHALL run a duration counter of at least 20 bits, cleared on every state entry, terminal at length-1.
REQ-020 SHALL drive ir_led during mark states (LEAD_M, BIT_M, STOP_M) from a carrier phase counter 0..2*CARRIER_HALF-1 cleared at each mark entry: ir_led=1 for phase < CARRIER_HALF, else 0; phase wraps to 0 after 2*CARRIER_HALF-1.
REQ-021 SHALL hold ir_led=0 in IDLE, LEAD_S and BIT_S.
REQ-022 SHALL assert busy in every non-IDLE state, i.e. from the cycle after start is accepted through the last STOP_M cycle.
REQ-023 SHALL assert done for exactly one cycle, the first IDLE cycle after STOP_M, coinciding with busy falling.
REQ-024 SHALL accept a start asserted in the done cycle, giving back-to-back frames with no gap cycle.
REQ-025 SHALL make frame length independent of data, since the payload always holds eight 1s and eight 0s: LEAD_MARK+LEAD_SPACE+16*BIT_MARK+8*ZERO_SPACE+8*ONE_SPACE+BIT_MARK cycles (2,053,125 at defaults).

Reset
REQ-026 SHALL, on rst_n=0 at a posedge, enter IDLE with ir_led=0, busy=0, done=0, all counters and bit index cleared, latched data cleared.
REQ-027 SHALL abort any frame in progress on reset mid-operation without emitting done; start is ignored while rst_n=0.

Verification (CARRIER_HALF=2, LEAD_MARK=16, LEAD_SPACE=8, BIT_MARK=4, ZERO_SPACE=4, ONE_SPACE=12)
REQ-028 SHALL cover: reset then idle 50 cycles -> ir_led=0, busy=0, done=0 throughout.
REQ-029 SHALL cover: start with data=8'hA5 -> busy high for exactly 220 cycles, done pulse one cycle, decoded space lengths give bits 1,0,1,0,0,1,0,1 then 0,1,0,1,1,0,1,0.
REQ-030 SHALL cover: leader -> ir_led pattern 1,1,0,0 repeated 4 times (16 cycles), then 8 cycles low.
REQ-031 SHALL cover: start pulsed again mid-frame and data changed to 8'h00 -> frame unchanged, still 8'hA5 payload, 220 cycles.
REQ-032 SHALL cover: start held high across done -> second frame begins in done cycle, busy low for 0 cycles, payload from data at that edge.
REQ-033 SHALL cover: rst_n low for 1 cycle at cycle 100 of a frame -> next cycle ir_led=0, busy=0, no done; subsequent start sends a full 220-cycle frame.

Source files
------------

// File: rtl/ir_nec_emitter.sv
// NEC infrared frame emitter: leader, 16-bit payload (byte then its complement,
// LSB first) and stop mark, with every mark modulated by a square-wave carrier.
module ir_nec_emitter #(
   parameter int CARRIER_HALF = 658,
   parameter int LEAD_MARK    = 450000,
   parameter int LEAD_SPACE   = 225000,
   parameter int BIT_MARK     = 28125,
   parameter int ZERO_SPACE   = 28125,
   parameter int ONE_SPACE    = 84375
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic [7:0] data,
   output logic       ir_led,
   output logic       busy,
   output logic       done
);

   localparam int MAX_A   = (LEAD_MARK > LEAD_SPACE) ? LEAD_MARK : LEAD_SPACE;
   localparam int MAX_B   = (BIT_MARK > ZERO_SPACE) ? BIT_MARK : ZERO_SPACE;
   localparam int MAX_C   = (ONE_SPACE > MAX_B) ? ONE_SPACE : MAX_B;
   localparam int MAX_LEN = (MAX_A > MAX_C) ? MAX_A : MAX_C;
   localparam int DUR_W   = ($clog2(MAX_LEN) > 20) ? $clog2(MAX_LEN) : 20;
   localparam int PH_W    = ($clog2(2 * CARRIER_HALF) > 1) ? $clog2(2 * CARRIER_HALF) : 1;
   localparam logic [PH_W-1:0] PH_LAST = PH_W'(2 * CARRIER_HALF - 1);
   localparam logic [PH_W-1:0] PH_HALF = PH_W'(CARRIER_HALF);

   typedef enum logic [2:0] {
      IDLE,
      LEAD_M,
      LEAD_S,
      BIT_M,
      BIT_S,
      STOP_M
   } state_t;

   state_t            state_q, state_d;
   logic [DUR_W-1:0]  dur_q, dur_d;
   logic [PH_W-1:0]   phase_q, phase_d;
   logic [3:0]        bit_idx_q, bit_idx_d;
   logic [7:0]        data_q, data_d;
   logic              done_q, done_d;

   logic [15:0]       payload;
   logic              cur_bit;
   logic              is_mark;
   logic [DUR_W-1:0]  dur_len;
   logic              dur_last;

   always_comb begin
      payload = {~data_q, data_q};
      cur_bit = payload[bit_idx_q];
      is_mark = (state_q == LEAD_M) || (state_q == BIT_M) || (state_q == STOP_M);
   end

   // Length of the current state; a space's length depends on the bit it follows.
   always_comb begin
      dur_len = DUR_W'(BIT_MARK);
      case (state_q)
         LEAD_M:  dur_len = DUR_W'(LEAD_MARK);
         LEAD_S:  dur_len = DUR_W'(LEAD_SPACE);
         BIT_S:   dur_len = cur_bit ? DUR_W'(ONE_SPACE) : DUR_W'(ZERO_SPACE);
         default: dur_len = DUR_W'(BIT_MARK);
      endcase
      dur_last = (dur_q == dur_len - DUR_W'(1));
   end

   always_comb begin
      state_d   = state_q;
      dur_d     = dur_q + DUR_W'(1);
      phase_d   = '0;
      bit_idx_d = bit_idx_q;
      data_d    = data_q;
      done_d    = 1'b0;

      if (is_mark) begin
         phase_d = (phase_q == PH_LAST) ? '0 : phase_q + PH_W'(1);
      end

      if (state_q == IDLE) begin
         dur_d = '0;
         if (start) begin
            state_d   = LEAD_M;
            data_d    = data;
            bit_idx_d = 4'd0;
         end
      end else if (dur_last) begin
         // Every state entry restarts both the duration and carrier counters.
         dur_d   = '0;
         phase_d = '0;
         case (state_q)
            LEAD_M: state_d = LEAD_S;
            LEAD_S: state_d = BIT_M;
            BIT_M:  state_d = BIT_S;
            BIT_S: begin
               if (bit_idx_q == 4'd15) begin
                  state_d   = STOP_M;
                  bit_idx_d = 4'd0;
               end else begin
                  state_d   = BIT_M;
                  bit_idx_d = bit_idx_q + 4'd1;
               end
            end
            STOP_M: begin
               state_d = IDLE;
               done_d  = 1'b1;
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         dur_q     <= '0;
         phase_q   <= '0;
         bit_idx_q <= 4'd0;
         data_q    <= 8'd0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         dur_q     <= dur_d;
         phase_q   <= phase_d;
         bit_idx_q <= bit_idx_d;
         data_q    <= data_d;
         done_q    <= done_d;
      end
   end

   assign ir_led = is_mark && (phase_q < PH_HALF);
   assign busy   = (state_q != IDLE);
   assign done   = done_q;

endmodule

// File: tb/tb_ir_nec_emitter.sv
// Bench for ir_nec_emitter: a cycle-level reference built from frame segments,
// table-driven frame decoding, hand-written corner cases and random traffic.
module tb_ir_nec_emitter;

   localparam int CH  = 2;
   localparam int LM  = 16;
   localparam int LS  = 8;
   localparam int BM  = 4;
   localparam int ZS  = 4;
   localparam int OS  = 12;
   localparam int FRAME_LEN = LM + LS + 16 * BM + 8 * ZS + 8 * OS + BM;

   logic       clk;
   logic       rst_n;
   logic       start;
   logic [7:0] data;
   logic       ir_led;
   logic       busy;
   logic       done;

   ir_nec_emitter #(
      .CARRIER_HALF(CH),
      .LEAD_MARK(LM),
      .LEAD_SPACE(LS),
      .BIT_MARK(BM),
      .ZERO_SPACE(ZS),
      .ONE_SPACE(OS)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .start(start),
      .data(data),
      .ir_led(ir_led),
      .busy(busy),
      .done(done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic led;
      logic busy;
      logic done;
   } out_t;

   typedef struct {
      logic [7:0]  d;
      logic [15:0] bits;
      int          len;
   } vec_t;

   out_t exp_q[$];
   int   tests = 0;
   int   fails = 0;
   logic last_led, last_busy, last_done;

   task automatic checkVal(input string name, input int act, input int expv);
      tests++;
      if (act !== expv) begin
         fails++;
         $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, expv, $time);
      end
   endtask

   // Expected waveform, written as marks and spaces of a given length.
   task automatic pushMark(input int n);
      out_t o;
      for (int j = 0; j < n; j++) begin
         o.led  = ((j % (2 * CH)) < CH);
         o.busy = 1'b1;
         o.done = 1'b0;
         exp_q.push_back(o);
      end
   endtask

   task automatic pushSpace(input int n);
      out_t o;
      o = '0;
      o.busy = 1'b1;
      for (int j = 0; j < n; j++) exp_q.push_back(o);
   endtask

   task automatic pushFrame(input logic [7:0] d);
      logic [15:0] payload;
      out_t o;
      payload = {~d, d};
      pushMark(LM);
      pushSpace(LS);
      for (int i = 0; i < 16; i++) begin
         pushMark(BM);
         pushSpace(payload[i] ? OS : ZS);
      end
      pushMark(BM);
      o = '0;
      o.done = 1'b1;
      exp_q.push_back(o);
   endtask

   task automatic checkOutput(input logic r, input logic s, input logic [7:0] d);
      out_t expo;
      expo = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
      last_led  = ir_led;
      last_busy = busy;
      last_done = done;
      checkVal("cycle_outputs", int'({ir_led, busy, done}), int'({expo.led, expo.busy, expo.done}));
      if (!r) exp_q.delete();
      else if (!expo.busy && s) pushFrame(d);
   endtask

   // Inputs change 1 time unit after the edge; outputs are read at the falling edge.
   task automatic applyStimulus(input logic r, input logic s, input logic [7:0] d);
      rst_n = r;
      start = s;
      data  = d;
      #4;
      checkOutput(r, s, d);
      @(posedge clk);
      #1;
   endtask

   // Runs a frame already started to completion and decodes it from ir_led.
   task automatic collectFrame(input string name, input logic [15:0] exp_bits,
                               input int exp_len, input bit poke);
      int          busy_len, dones, run, nlong, bad, leader_run;
      logic [15:0] bits;
      logic [23:0] lead_pat;
      logic        trace[$];
      busy_len = 0; dones = 0; run = 0; nlong = 0; bad = 0; leader_run = 0;
      bits = '0; lead_pat = '0;
      for (int i = 0; i < 400; i++) begin
         if (poke && i >= 40 && i < 46) applyStimulus(1'b1, 1'b1, 8'h00);
         else applyStimulus(1'b1, 1'b0, poke ? 8'h00 : 8'($urandom));
         if (i == 0) checkVal({name, "_first_busy"}, int'(last_busy), 1);
         if (last_busy) begin
            busy_len++;
            trace.push_back(last_led);
         end
         if (last_done) begin
            dones++;
            break;
         end
      end
      checkVal({name, "_done_seen"}, dones, 1);
      checkVal({name, "_busy_len"}, busy_len, exp_len);
      for (int j = 0; j < 24; j++)
         lead_pat = {lead_pat[22:0], (j < trace.size()) ? trace[j] : 1'b1};
      checkVal({name, "_leader_pattern"}, int'(lead_pat), int'(24'hCCCC00));
      foreach (trace[k]) begin
         if (trace[k] == 1'b0) run++;
         else begin
            if (run > 2) begin
               if (nlong == 0) leader_run = run;
               else begin
                  if (nlong <= 16) bits[nlong-1] = (run > 8);
                  if (run != 2 + ZS && run != 2 + OS) bad++;
               end
               nlong++;
            end
            run = 0;
         end
      end
      checkVal({name, "_leader_low_run"}, leader_run, 2 + LS);
      checkVal({name, "_bit_count"}, nlong - 1, 16);
      checkVal({name, "_bad_spaces"}, bad, 0);
      checkVal({name, "_payload"}, int'(bits), int'(exp_bits));
      applyStimulus(1'b1, 1'b0, 8'h00);
      checkVal({name, "_done_one_cycle"}, int'(last_done), 0);
   endtask

   initial begin
      vec_t vecs[5];
      int   gap, dones, busies;
      vecs[0] = '{d: 8'hA5, bits: 16'h5AA5, len: 220};
      vecs[1] = '{d: 8'h00, bits: 16'hFF00, len: 220};
      vecs[2] = '{d: 8'hFF, bits: 16'h00FF, len: 220};
      vecs[3] = '{d: 8'h01, bits: 16'hFE01, len: 220};
      vecs[4] = '{d: 8'h3C, bits: 16'hC33C, len: 220};

      rst_n = 1'b0; start = 1'b0; data = 8'h00;
      @(posedge clk);
      #1;
      applyStimulus(1'b0, 1'b1, 8'h55);
      applyStimulus(1'b0, 1'b0, 8'h00);

      // Quiet idle after reset, with noise on data.
      repeat (50) applyStimulus(1'b1, 1'b0, 8'($urandom));

      for (int v = 0; v < 5; v++) begin
         applyStimulus(1'b1, 1'b1, vecs[v].d);
         collectFrame($sformatf("vec%0d", v), vecs[v].bits, vecs[v].len, 1'b0);
         checkVal("frame_len_rule", vecs[v].len, FRAME_LEN);
      end

      // Start re-pulsed and data cleared mid-frame.
      applyStimulus(1'b1, 1'b1, 8'hA5);
      collectFrame("midstart", 16'h5AA5, 220, 1'b1);

      // Start held high across done: the second frame starts in the done cycle.
      applyStimulus(1'b1, 1'b1, 8'hA5);
      gap = 0; dones = 0;
      for (int i = 0; i < 400; i++) begin
         applyStimulus(1'b1, 1'b1, 8'h3C);
         if (!last_busy && !last_done) gap++;
         if (last_done) begin
            dones++;
            break;
         end
      end
      checkVal("b2b_first_done", dones, 1);
      checkVal("b2b_idle_gap", gap, 0);
      collectFrame("b2b_second", 16'hC33C, 220, 1'b0);

      // Reset one cycle at cycle 100 of a frame; start during reset is ignored.
      applyStimulus(1'b1, 1'b1, 8'hA5);
      repeat (99) applyStimulus(1'b1, 1'b0, 8'hA5);
      applyStimulus(1'b0, 1'b1, 8'h3C);
      applyStimulus(1'b1, 1'b0, 8'h00);
      checkVal("rst_busy", int'(last_busy), 0);
      checkVal("rst_led", int'(last_led), 0);
      checkVal("rst_done", int'(last_done), 0);
      dones = 0; busies = 0;
      repeat (300) begin
         applyStimulus(1'b1, 1'b0, 8'($urandom));
         if (last_done) dones++;
         if (last_busy) busies++;
      end
      checkVal("rst_no_done", dones, 0);
      checkVal("rst_stays_idle", busies, 0);
      applyStimulus(1'b1, 1'b1, 8'hA5);
      collectFrame("after_rst", 16'h5AA5, 220, 1'b0);

      // Random traffic against the reference waveform.
      for (int i = 0; i < 3000; i++) begin
         applyStimulus(($urandom_range(0, 399) != 0), ($urandom_range(0, 15) == 0), 8'($urandom));
      end
      repeat (230) applyStimulus(1'b1, 1'b0, 8'($urandom));

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
